node_link_scheduler: RTL and testbench



---
 rtl/node_link_scheduler_pkg.sv | 16 +
 rtl/node_link_scheduler_link_serializer.sv | 57 +++++
 rtl/node_link_scheduler.sv | 139 +++++++++++++
 tb/tb_node_link_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/node_link_scheduler_pkg.sv
// rtl/node_link_scheduler_pkg.sv - shared types and constants for the node link scheduler
package node_link_scheduler_pkg;

    typedef enum logic [2:0] {
        OFFER,
        WAIT,
        RECV,
        XWAIT,
        XMIT
    } sched_state_t;

    localparam int PKT_BYTES = 4;

    typedef logic [1:0] byte_idx_t;

endpackage

// File: rtl/node_link_scheduler_link_serializer.sv
// rtl/node_link_scheduler_link_serializer.sv - packet buffer and downstream byte replay
module link_serializer
    import node_link_scheduler_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [1:0] wr_idx,
    input  logic [7:0] wr_data,
    input  logic       clear,
    input  logic       start,
    output logic       put_out,
    output logic [7:0] payload_out,
    output logic       done
);

    localparam byte_idx_t LAST_IDX = byte_idx_t'(PKT_BYTES - 1);

    logic [PKT_BYTES-1:0][7:0] buf_q;
    byte_idx_t                 tx_idx;
    byte_idx_t                 tx_next;

    assign tx_next = tx_idx + 2'd1;
    // High during the cycle that presents the final byte.
    assign done    = put_out && (tx_idx == LAST_IDX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_q       <= '0;
            put_out     <= 1'b0;
            payload_out <= 8'h00;
            tx_idx      <= '0;
        end else begin
            if (clear) begin
                buf_q <= '0;
            end else if (wr_en) begin
                buf_q[wr_idx] <= wr_data;
            end

            if (start) begin
                put_out     <= 1'b1;
                payload_out <= buf_q[0];
                tx_idx      <= '0;
            end else if (put_out) begin
                if (tx_idx == LAST_IDX) begin
                    put_out     <= 1'b0;
                    payload_out <= 8'h00;
                    tx_idx      <= '0;
                end else begin
                    payload_out <= buf_q[tx_next];
                    tx_idx      <= tx_next;
                end
            end
        end
    end

endmodule

// File: rtl/node_link_scheduler.sv
// rtl/node_link_scheduler.sv - round-robin poller sharing one downstream link among node links
module node_link_scheduler
    import node_link_scheduler_pkg::*;
#(
    parameter int NUM_NODES = 4,
    parameter int PKT_BYTES = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    output logic [NUM_NODES-1:0]         free_in,
    input  logic [NUM_NODES-1:0]         put_in,
    input  logic [NUM_NODES*8-1:0]       payload_in,
    input  logic                         free_out,
    output logic                         put_out,
    output logic [7:0]                   payload_out,
    output logic [$clog2(NUM_NODES)-1:0] src_id,
    output logic                         err_short,
    output logic                         err_stray
);

    localparam int                PTR_W     = $clog2(NUM_NODES);
    localparam logic [PTR_W-1:0]  LAST_NODE = PTR_W'(NUM_NODES - 1);
    localparam byte_idx_t         LAST_BYTE = byte_idx_t'(PKT_BYTES - 1);

    sched_state_t     state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_next, src_d;
    byte_idx_t        cnt_q, cnt_d, wr_idx;
    logic             live_q;
    logic             wr_en, clear, start, tx_done;
    logic             short_d, stray_d;
    logic             cur_put;
    logic [7:0]       cur_byte;

    function automatic logic [NUM_NODES-1:0] grant_of(input logic [PTR_W-1:0] p);
        logic [NUM_NODES-1:0] g;
        g    = '0;
        g[p] = 1'b1;
        return g;
    endfunction

    assign cur_put  = put_in[ptr_q];
    assign cur_byte = payload_in[ptr_q*8 +: 8];
    assign ptr_next = (ptr_q == LAST_NODE) ? '0 : ptr_q + 1'b1;
    assign wr_idx   = (state_q == WAIT) ? '0 : cnt_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        src_d   = src_id;
        wr_en   = 1'b0;
        clear   = 1'b0;
        start   = 1'b0;
        short_d = 1'b0;
        // The first cycle after reset only primes the registered free_in strobe.
        if (live_q) begin
            case (state_q)
                OFFER: state_d = WAIT;
                WAIT: begin
                    if (cur_put) begin
                        wr_en   = 1'b1;
                        cnt_d   = byte_idx_t'(1);
                        state_d = RECV;
                    end else begin
                        ptr_d   = ptr_next;
                        state_d = OFFER;
                    end
                end
                RECV: begin
                    if (cur_put) begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == LAST_BYTE) begin
                            src_d   = ptr_q;
                            ptr_d   = ptr_next;
                            cnt_d   = '0;
                            state_d = XWAIT;
                        end
                    end else begin
                        short_d = 1'b1;
                        clear   = 1'b1;
                        cnt_d   = '0;
                        ptr_d   = ptr_next;
                        state_d = OFFER;
                    end
                end
                XWAIT: begin
                    if (free_out) begin
                        start   = 1'b1;
                        state_d = XMIT;
                    end
                end
                XMIT: begin
                    if (tx_done) state_d = OFFER;
                end
                default: state_d = OFFER;
            endcase
        end
    end

    assign stray_d = (|(put_in & ~grant_of(ptr_q))) ||
                     (cur_put && (state_q != WAIT) && (state_q != RECV));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= OFFER;
            ptr_q     <= '0;
            cnt_q     <= '0;
            src_id    <= '0;
            live_q    <= 1'b0;
            free_in   <= '0;
            err_short <= 1'b0;
            err_stray <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            src_id    <= src_d;
            live_q    <= 1'b1;
            free_in   <= (state_d == OFFER) ? grant_of(ptr_d) : '0;
            err_short <= short_d;
            err_stray <= stray_d;
        end
    end

    link_serializer u_link_serializer (
        .clock       (clock),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_data     (cur_byte),
        .clear       (clear),
        .start       (start),
        .put_out     (put_out),
        .payload_out (payload_out),
        .done        (tx_done)
    );

endmodule

// File: tb/tb_node_link_scheduler.sv
// tb/tb_node_link_scheduler.sv - directed self-checking bench for node_link_scheduler
module tb_node_link_scheduler;

    localparam int N = 4;

    logic           clock;
    logic           reset_n;
    logic [N-1:0]   free_in;
    logic [N-1:0]   put_in;
    logic [N*8-1:0] payload_in;
    logic           free_out;
    logic           put_out;
    logic [7:0]     payload_out;
    logic [1:0]     src_id;
    logic           err_short;
    logic           err_stray;

    node_link_scheduler #(.NUM_NODES(N), .PKT_BYTES(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .free_in     (free_in),
        .put_in      (put_in),
        .payload_in  (payload_in),
        .free_out    (free_out),
        .put_out     (put_out),
        .payload_out (payload_out),
        .src_id      (src_id),
        .err_short   (err_short),
        .err_stray   (err_stray)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Node models: a ready node answers a free_in strobe with node_len bytes.
    logic [N-1:0] node_ready;
    logic [N-1:0] stray_mask;
    int           node_len [N];
    logic [7:0]   node_pkt [N][4];
    int           act_cnt  [N];
    int           act_idx  [N];
    logic [N-1:0] seen;

    initial begin
        put_in     = '0;
        payload_in = '0;
        for (int i = 0; i < N; i++) begin
            act_cnt[i] = 0;
            act_idx[i] = 0;
        end
        forever begin
            @(negedge clock);
            seen = free_in;
            @(posedge clock);
            #1;
            for (int i = 0; i < N; i++) begin
                if (act_cnt[i] == 0 && seen[i] && node_ready[i]) begin
                    act_cnt[i] = node_len[i];
                    act_idx[i] = 0;
                end
                if (act_cnt[i] > 0) begin
                    put_in[i]            = 1'b1;
                    payload_in[i*8 +: 8] = node_pkt[i][act_idx[i]];
                    act_idx[i]++;
                    act_cnt[i]--;
                end else if (stray_mask[i]) begin
                    put_in[i]            = 1'b1;
                    payload_in[i*8 +: 8] = 8'hEE;
                end else begin
                    put_in[i]            = 1'b0;
                    payload_in[i*8 +: 8] = 8'h00;
                end
            end
        end
    end

    // Downstream monitor collecting whole put_out bursts.
    int          pk_n = 0;
    int          run  = 0;
    logic [31:0] cur_data;
    logic [1:0]  cur_src;
    logic [1:0]  pk_src  [64];
    int          pk_len  [64];
    logic [31:0] pk_data [64];

    initial begin
        cur_data = '0;
        cur_src  = '0;
        forever begin
            @(negedge clock);
            if (put_out) begin
                cur_data = {cur_data[23:0], payload_out};
                cur_src  = src_id;
                run++;
            end else if (run != 0) begin
                if (pk_n < 64) begin
                    pk_src[pk_n]  = cur_src;
                    pk_len[pk_n]  = run;
                    pk_data[pk_n] = cur_data;
                    pk_n++;
                end
                run = 0;
            end
        end
    end

    task automatic do_reset();
        reset_n    = 1'b0;
        node_ready = '0;
        stray_mask = '0;
        free_out   = 1'b1;
        for (int i = 0; i < N; i++) node_len[i] = 4;
        repeat (6) @(negedge clock);
        reset_n = 1'b1;
    endtask

    logic [3:0] t1_exp [9];
    int         bad;
    int         pulses;
    int         base;
    int         waited;
    logic [31:0] exp_data;

    initial begin
        reset_n    = 1'b0;
        free_out   = 1'b1;
        node_ready = '0;
        stray_mask = '0;
        for (int i = 0; i < N; i++) begin
            node_len[i] = 4;
            for (int b = 0; b < 4; b++) node_pkt[i][b] = 8'h00;
        end

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_free_in", 32'(free_in), 32'h0);
        check("rst_put_out", 32'(put_out), 32'h0);
        check("rst_payload", 32'(payload_out), 32'h0);
        check("rst_src_id", 32'(src_id), 32'h0);
        check("rst_err", 32'({err_short, err_stray}), 32'h0);

        // 1: idle polling cadence
        t1_exp = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        do_reset();
        bad = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            check($sformatf("t1_free_%0d", k), 32'(free_in), 32'(t1_exp[k]));
            if (put_out) bad++;
        end
        check("t1_no_put", 32'(bad), 32'h0);

        // 2: node 2 single packet
        node_pkt[2][0] = 8'hA1; node_pkt[2][1] = 8'hB2;
        node_pkt[2][2] = 8'hC3; node_pkt[2][3] = 8'hD4;
        do_reset();
        node_ready = 4'b0100;
        repeat (5) @(negedge clock);
        check("t2_offer", 32'(free_in), 32'h4);
        repeat (5) @(negedge clock);
        check("t2_xwait_idle", 32'(put_out), 32'h0);
        @(negedge clock);
        check("t2_src", 32'(src_id), 32'h2);
        for (int b = 0; b < 4; b++) begin
            if (b != 0) @(negedge clock);
            check($sformatf("t2_put_%0d", b), 32'(put_out), 32'h1);
            check($sformatf("t2_byte_%0d", b), 32'(payload_out), 32'(node_pkt[2][b]));
        end
        @(negedge clock);
        check("t2_put_end", 32'(put_out), 32'h0);
        check("t2_next_offer", 32'(free_in), 32'h8);

        // 3: all nodes continuously ready
        for (int i = 0; i < N; i++)
            for (int b = 0; b < 4; b++) node_pkt[i][b] = 8'((i << 4) | b);
        do_reset();
        node_ready = 4'b1111;
        base   = pk_n;
        waited = 0;
        while ((pk_n - base) < 8 && waited < 300) begin
            @(negedge clock);
            #1;
            waited++;
        end
        check("t3_timeout", 32'(pk_n - base >= 8), 32'h1);
        for (int k = 0; k < 8; k++) begin
            exp_data = {4'(k % 4), 4'h0, 4'(k % 4), 4'h1, 4'(k % 4), 4'h2, 4'(k % 4), 4'h3};
            check($sformatf("t3_src_%0d", k), 32'(pk_src[base + k]), 32'(k % 4));
            check($sformatf("t3_len_%0d", k), 32'(pk_len[base + k]), 32'd4);
            check($sformatf("t3_data_%0d", k), pk_data[base + k], exp_data);
        end

        // 4: downstream back-pressure
        node_pkt[0][0] = 8'h5A; node_pkt[0][1] = 8'h3C;
        node_pkt[0][2] = 8'h96; node_pkt[0][3] = 8'h0F;
        do_reset();
        free_out   = 1'b0;
        node_ready = 4'b0001;
        repeat (5) @(negedge clock);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (free_in != 0 || put_out) bad++;
        end
        check("t4_hold", 32'(bad), 32'h0);
        free_out   = 1'b1;
        node_ready = '0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clock);
            check($sformatf("t4_byte_%0d", b), 32'({put_out, payload_out}), 32'({1'b1, node_pkt[0][b]}));
        end
        @(negedge clock);
        check("t4_resume", 32'(free_in), 32'h2);

        // 5a: short packet from node 1
        do_reset();
        node_len[1] = 2;
        node_ready  = 4'b0010;
        repeat (7) @(negedge clock);
        node_ready = '0;
        check("t5_err_short", 32'(err_short), 32'h1);
        check("t5_next_offer", 32'(free_in), 32'h4);
        pulses = 0;
        bad    = 0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clock);
            if (err_short) pulses++;
            if (put_out) bad++;
        end
        check("t5_short_once", 32'(pulses), 32'h0);
        check("t5_no_put", 32'(bad), 32'h0);

        // 5b: stray put from node 3 while node 1 is granted
        node_pkt[1][0] = 8'h11; node_pkt[1][1] = 8'h22;
        node_pkt[1][2] = 8'h33; node_pkt[1][3] = 8'h44;
        do_reset();
        node_ready = 4'b0010;
        repeat (4) @(negedge clock);
        stray_mask = 4'b1000;
        @(negedge clock);
        stray_mask = '0;
        @(negedge clock);
        check("t5_err_stray", 32'(err_stray), 32'h1);
        @(negedge clock);
        check("t5_stray_pulse", 32'(err_stray), 32'h0);
        node_ready = '0;
        repeat (2) @(negedge clock);
        check("t5_src", 32'(src_id), 32'h1);
        for (int b = 0; b < 4; b++) begin
            if (b != 0) @(negedge clock);
            check($sformatf("t5_byte_%0d", b), 32'({put_out, payload_out}), 32'({1'b1, node_pkt[1][b]}));
        end

        // 6: reset during transmit
        do_reset();
        node_ready = 4'b0001;
        repeat (8) @(negedge clock);
        check("t6_mid_byte", 32'({put_out, payload_out}), 32'({1'b1, node_pkt[0][1]}));
        reset_n = 1'b0;
        #1;
        check("t6_async_put", 32'(put_out), 32'h0);
        check("t6_async_payload", 32'(payload_out), 32'h0);
        do_reset();
        @(negedge clock);
        check("t6_first_offer", 32'(free_in), 32'h1);
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (put_out) bad++;
        end
        check("t6_no_stale", 32'(bad), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
